ms6205_responder: RTL and testbench

Behavioural and synthesizable model of the MS6205 character display as seen from its bus: the peripheral end of the ms6205 write_addr_n / write_data_n / marker / ready interface driven by the emulator sequencer.
- Latches addresses and characters from the shared 8-bit emulator data bus into a screen buffer.
- Throttles the host via ready.
- Exposes a read port and status outputs for bench checking and for an on-FPGA mirror.

---
 rtl/ms6205_responder_if.sv | 29 ++
 rtl/ms6205_responder.sv | 218 +++++++++++++++++++++
 tb/tb_ms6205_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ms6205_responder_if.sv
// Bus between the emulator sequencer (master) and the MS6205 display
// responder (slave): write strobes, marker request, ready throttle, plus the
// read/status port used by checkers and an on-FPGA mirror.
interface ms6205_responder_if;
    logic [7:0]  bus_data;      // shared emulator data bus
    logic        write_addr_n;  // active-low address strobe
    logic        write_data_n;  // active-low data strobe
    logic        marker;        // cursor marker request
    logic        ready;         // high when a strobe can be accepted
    logic [7:0]  rd_addr;       // buffer read address
    logic [7:0]  rd_data;       // buffer read data, registered
    logic [7:0]  cur_addr;      // current write pointer
    logic [7:0]  marker_pos;    // latched marker position
    logic        marker_valid;  // marker_pos holds a valid position
    logic [15:0] write_count;   // accepted data writes, wrapping
    logic        proto_err;     // sticky protocol-violation flag

    modport master (
        output bus_data, write_addr_n, write_data_n, marker, rd_addr,
        input  ready, rd_data, cur_addr, marker_pos, marker_valid,
               write_count, proto_err
    );

    modport slave (
        input  bus_data, write_addr_n, write_data_n, marker, rd_addr,
        output ready, rd_data, cur_addr, marker_pos, marker_valid,
               write_count, proto_err
    );
endinterface

// File: rtl/ms6205_responder.sv
// MS6205 character display, bus side. Address and data strobes are
// falling-edge detected against the previous sample; accepted characters
// land in a DEPTH-entry screen buffer. ready drops for BUSY_CYCLES after each
// data write and for the whole clear pass. Any strobe the block cannot honour
// sets a sticky proto_err.
module ms6205_responder #(
    parameter int unsigned DEPTH       = 160,   // characters, at most 255
    parameter int unsigned BUSY_CYCLES = 4,     // at least 1
    parameter logic [7:0]  CLEAR_CODE  = 8'hFF,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
    input  logic Clk,
    input  logic Rst_n,
    ms6205_responder_if.slave bus
);

    localparam int unsigned CNT_W    = $clog2(BUSY_CYCLES + 1);
    localparam logic [7:0]  DEPTH_B  = 8'(DEPTH);
    localparam logic [7:0]  LAST_IDX = 8'(DEPTH - 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Control state
    state_e           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    // Architectural outputs
    logic [7:0]       cur_addr_q, cur_addr_d;
    logic [7:0]       marker_pos_q, marker_pos_d;
    logic             marker_valid_q, marker_valid_d;
    logic [15:0]      write_count_q, write_count_d;
    logic             proto_err_q, proto_err_d;
    logic [7:0]       rd_data_q;

    // Input history for edge detection
    logic             addr_n_q;
    logic             data_n_q;
    logic             marker_q;

    // Buffer write port
    logic             mem_we;
    logic [7:0]       mem_waddr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem [DEPTH];

    logic             addr_fall;
    logic             data_fall;
    logic             marker_rise;
    logic [7:0]       cur_addr_inc;

    assign addr_fall    = addr_n_q & ~bus.write_addr_n;
    assign data_fall    = data_n_q & ~bus.write_data_n;
    assign marker_rise  = ~marker_q & bus.marker;
    assign cur_addr_inc = (cur_addr_q == LAST_IDX) ? 8'd0 : cur_addr_q + 8'd1;

    // Sample strobe/marker history; idle levels are strobes high, marker low.
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: non-blocking assignments make every register see pre-edge
        // values, so edge detection and read-old-data fall out naturally.
        if (!Rst_n) begin
            addr_n_q <= 1'b1;
            data_n_q <= 1'b1;
            marker_q <= 1'b0;
        end else begin
            addr_n_q <= bus.write_addr_n;
            data_n_q <= bus.write_data_n;
            marker_q <= bus.marker;
        end
    end

    // State and output registers; reset always restarts with a full clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= ST_CLEAR;
            idx_q          <= 8'd0;
            cnt_q          <= '0;
            ready_q        <= 1'b0;
            cur_addr_q     <= 8'd0;
            marker_pos_q   <= 8'd0;
            marker_valid_q <= 1'b0;
            write_count_q  <= 16'd0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            ready_q        <= ready_d;
            cur_addr_q     <= cur_addr_d;
            marker_pos_q   <= marker_pos_d;
            marker_valid_q <= marker_valid_d;
            write_count_q  <= write_count_d;
            proto_err_q    <= proto_err_d;
        end
    end

    // Next-state logic: strobe decoding, clear sweep, busy countdown.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        cur_addr_d     = cur_addr_q;
        marker_pos_d   = marker_pos_q;
        marker_valid_d = marker_valid_q;
        write_count_d  = write_count_q;
        proto_err_d    = proto_err_q;
        mem_we         = 1'b0;
        mem_waddr      = cur_addr_q;
        mem_wdata      = bus.bus_data;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = BLANK_CHAR;
                if (addr_fall || data_fall) begin
                    proto_err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end

            ST_BUSY: begin
                if (addr_fall || data_fall) begin
                    proto_err_d = 1'b1;
                end
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_IDLE: begin
                if (addr_fall && data_fall) begin
                    // One bus value, two meanings: reject both.
                    proto_err_d = 1'b1;
                end else if (addr_fall) begin
                    if (bus.bus_data < DEPTH_B) begin
                        cur_addr_d = bus.bus_data;
                    end else if (bus.bus_data == CLEAR_CODE) begin
                        state_d        = ST_CLEAR;
                        cur_addr_d     = 8'd0;
                        marker_valid_d = 1'b0;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end else if (data_fall) begin
                    mem_we        = 1'b1;
                    cur_addr_d    = cur_addr_inc;
                    write_count_d = write_count_q + 16'd1;
                    cnt_d         = BUSY_LOAD;
                    state_d       = ST_BUSY;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                idx_d   = 8'd0;
            end
        endcase

        // Marker latches the pointer as it was before this cycle's update.
        if (marker_rise) begin
            marker_pos_d   = cur_addr_q;
            marker_valid_d = 1'b1;
        end
    end

    // ready follows the state being entered, so it changes one cycle after
    // the edge that caused the transition.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
    end

    // Screen buffer write port.
    always_ff @(posedge Clk) begin
        // NOTE: the buffer has no reset so it maps onto block RAM; the clear
        // pass that follows every reset blanks it instead.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_data_q <= 8'h00;
        end else if (bus.rd_addr < DEPTH_B) begin
            rd_data_q <= mem[bus.rd_addr];
        end else begin
            rd_data_q <= 8'h00;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.cur_addr     = cur_addr_q;
    assign bus.marker_pos   = marker_pos_q;
    assign bus.marker_valid = marker_valid_q;
    assign bus.write_count  = write_count_q;
    assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_ms6205_responder.sv
// Bench for the MS6205 display responder: directed sequences, a write-vector
// table and randomized traffic, all compared against a transaction-level
// model of the display kept here.
module tb_ms6205_responder;

    localparam int         DEPTH = 160;
    localparam int         BUSY  = 4;
    localparam logic [7:0] CLR   = 8'hFF;
    localparam logic [7:0] BLANK = 8'h20;

    logic Clk;
    logic Rst_n;

    ms6205_responder_if bus_if();

    ms6205_responder #(
        .DEPTH      (DEPTH),
        .BUSY_CYCLES(BUSY),
        .CLEAR_CODE (CLR),
        .BLANK_CHAR (BLANK)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus_if)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: screen contents, pointer, counters, and the number of
    // cycles the display still refuses strobes.
    logic [7:0]  m_mem [DEPTH];
    logic [7:0]  m_cur;
    logic [7:0]  m_mpos;
    logic        m_mvalid;
    logic        m_perr;
    logic [15:0] m_count;
    int          m_busy_left;
    bit          m_in_clear;
    logic        m_prev_a;
    logic        m_prev_d;
    logic        m_prev_m;

    typedef struct {
        bit          do_addr;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [7:0]  wr_at;
        logic [7:0]  exp_cur;
        logic [15:0] exp_count;
    } wr_vec_t;

    wr_vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = BLANK;
        m_cur       = 8'd0;
        m_mpos      = 8'd0;
        m_mvalid    = 1'b0;
        m_perr      = 1'b0;
        m_count     = 16'd0;
        m_busy_left = DEPTH;
        m_in_clear  = 1'b1;
        m_prev_a    = 1'b1;
        m_prev_d    = 1'b1;
        m_prev_m    = 1'b0;
    endtask

    // Advance one clock with the inputs currently driven; model and DUT are
    // compared #1 after the edge.
    task automatic step();
        logic       a_fall;
        logic       d_fall;
        logic       m_rise;
        logic [7:0] old_cur;
        logic [7:0] exp_rd;
        bit         rd_ok;

        a_fall  = m_prev_a & ~bus_if.write_addr_n;
        d_fall  = m_prev_d & ~bus_if.write_data_n;
        m_rise  = ~m_prev_m & bus_if.marker;
        rd_ok   = !m_in_clear;
        exp_rd  = 8'h00;
        if (int'(bus_if.rd_addr) < DEPTH) exp_rd = m_mem[bus_if.rd_addr];
        old_cur = m_cur;

        if (m_busy_left > 0) begin
            if (a_fall || d_fall) m_perr = 1'b1;
            m_busy_left--;
            if (m_busy_left == 0) m_in_clear = 1'b0;
        end else if (a_fall && d_fall) begin
            m_perr = 1'b1;
        end else if (a_fall) begin
            if (int'(bus_if.bus_data) < DEPTH) begin
                m_cur = bus_if.bus_data;
            end else if (bus_if.bus_data == CLR) begin
                m_cur       = 8'd0;
                m_mvalid    = 1'b0;
                m_busy_left = DEPTH;
                m_in_clear  = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = BLANK;
            end else begin
                m_perr = 1'b1;
            end
        end else if (d_fall) begin
            m_mem[m_cur] = bus_if.bus_data;
            m_cur        = 8'((int'(m_cur) + 1) % DEPTH);
            m_count      = m_count + 16'd1;
            m_busy_left  = BUSY;
        end
        if (m_rise) begin
            m_mpos   = old_cur;
            m_mvalid = 1'b1;
        end
        m_prev_a = bus_if.write_addr_n;
        m_prev_d = bus_if.write_data_n;
        m_prev_m = bus_if.marker;

        @(posedge Clk);
        #1;
        check("model ready",        32'(bus_if.ready),        32'(m_busy_left == 0));
        check("model cur_addr",     32'(bus_if.cur_addr),     32'(m_cur));
        check("model write_count",  32'(bus_if.write_count),  32'(m_count));
        check("model proto_err",    32'(bus_if.proto_err),    32'(m_perr));
        check("model marker_valid", 32'(bus_if.marker_valid), 32'(m_mvalid));
        check("model marker_pos",   32'(bus_if.marker_pos),   32'(m_mpos));
        if (rd_ok) check("model rd_data", 32'(bus_if.rd_data), 32'(exp_rd));
    endtask

    // Step until ready, bounded; n is the number of steps taken.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus_if.ready && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_addr(input logic [7:0] a);
        bus_if.bus_data     = a;
        bus_if.write_addr_n = 1'b0;
        step();
        bus_if.write_addr_n = 1'b1;
        step();
    endtask

    // Data strobe; low_cycles is how long ready stayed low afterwards.
    task automatic write_data(input logic [7:0] d, output int low_cycles);
        bus_if.bus_data     = d;
        bus_if.write_data_n = 1'b0;
        step();
        bus_if.write_data_n = 1'b1;
        wait_ready(low_cycles);
    endtask

    task automatic start_clear(output int low_cycles);
        bus_if.bus_data     = CLR;
        bus_if.write_addr_n = 1'b0;
        step();
        bus_if.write_addr_n = 1'b1;
        wait_ready(low_cycles);
    endtask

    task automatic read_at(input logic [7:0] a, output logic [7:0] d);
        bus_if.rd_addr = a;
        step();
        d = bus_if.rd_data;
    endtask

    task automatic apply_reset();
        Rst_n               = 1'b0;
        bus_if.write_addr_n = 1'b1;
        bus_if.write_data_n = 1'b1;
        bus_if.marker       = 1'b0;
        #1;
        check("reset ready",        32'(bus_if.ready),        32'd0);
        check("reset cur_addr",     32'(bus_if.cur_addr),     32'd0);
        check("reset marker_pos",   32'(bus_if.marker_pos),   32'd0);
        check("reset marker_valid", 32'(bus_if.marker_valid), 32'd0);
        check("reset write_count",  32'(bus_if.write_count),  32'd0);
        check("reset proto_err",    32'(bus_if.proto_err),    32'd0);
        check("reset rd_data",      32'(bus_if.rd_data),      32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] rd;

        vecs[0] = '{1'b1, 8'd17,  8'h41, 8'd17,  8'd18,  16'd1};
        vecs[1] = '{1'b1, 8'd159, 8'h42, 8'd159, 8'd0,   16'd2};
        vecs[2] = '{1'b0, 8'd0,   8'h43, 8'd0,   8'd1,   16'd3};
        vecs[3] = '{1'b1, 8'd100, 8'h00, 8'd100, 8'd101, 16'd4};
        vecs[4] = '{1'b0, 8'd0,   8'hA5, 8'd101, 8'd102, 16'd5};
        vecs[5] = '{1'b1, 8'd17,  8'h5A, 8'd17,  8'd18,  16'd6};

        Rst_n               = 1'b0;
        bus_if.bus_data     = 8'h00;
        bus_if.write_addr_n = 1'b1;
        bus_if.write_data_n = 1'b1;
        bus_if.marker       = 1'b0;
        bus_if.rd_addr      = 8'h00;
        model_reset();
        @(posedge Clk);
        #1;

        // Power-up clear and blank screen.
        apply_reset();
        wait_ready(n);
        check("post-reset clear length", 32'(n), 32'd160);
        for (int i = 0; i < DEPTH; i++) begin
            read_at(8'(i), rd);
            check("blank after clear", 32'(rd), 32'(BLANK));
        end
        check("cur_addr after clear",    32'(bus_if.cur_addr),    32'd0);
        check("write_count after clear", 32'(bus_if.write_count), 32'd0);

        // Write vectors, including pointer wrap at the last location.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_addr) pulse_addr(vecs[v].addr);
            write_data(vecs[v].data, n);
            check("busy window length", 32'(n), 32'(BUSY));
            check("vec cur_addr",       32'(bus_if.cur_addr),    32'(vecs[v].exp_cur));
            check("vec write_count",    32'(bus_if.write_count), 32'(vecs[v].exp_count));
            read_at(vecs[v].wr_at, rd);
            check("vec readback",       32'(rd), 32'(vecs[v].data));
        end
        read_at(8'd159, rd);
        check("wrap keeps last cell", 32'(rd), 32'h42);
        read_at(8'd0, rd);
        check("wrap wrote cell 0",    32'(rd), 32'h43);
        read_at(8'd200, rd);
        check("out-of-range read",    32'(rd), 32'h00);
        check("no proto_err yet",     32'(bus_if.proto_err), 32'd0);

        // Data strobe while busy is dropped and flagged.
        bus_if.bus_data     = 8'h11;
        bus_if.write_data_n = 1'b0;
        step();
        bus_if.write_data_n = 1'b1;
        step();
        bus_if.bus_data     = 8'h22;
        bus_if.write_data_n = 1'b0;
        step();
        bus_if.write_data_n = 1'b1;
        wait_ready(n);
        check("busy strobe proto_err",   32'(bus_if.proto_err),   32'd1);
        check("busy strobe write_count", 32'(bus_if.write_count), 32'd7);
        check("busy strobe cur_addr",    32'(bus_if.cur_addr),    32'd19);
        read_at(8'd18, rd);
        check("first write landed",      32'(rd), 32'h11);
        read_at(8'd19, rd);
        check("second write dropped",    32'(rd), 32'(BLANK));

        // Out-of-range address.
        apply_reset();
        wait_ready(n);
        check("clear length #2", 32'(n), 32'd160);
        pulse_addr(8'd200);
        check("bad addr proto_err", 32'(bus_if.proto_err), 32'd1);
        check("bad addr cur_addr",  32'(bus_if.cur_addr),  32'd0);

        // Marker, then host-commanded clear.
        apply_reset();
        wait_ready(n);
        pulse_addr(8'd5);
        write_data(8'h55, n);
        check("cur_addr after 0x55", 32'(bus_if.cur_addr), 32'd6);
        bus_if.marker = 1'b1;
        step();
        check("marker_pos",   32'(bus_if.marker_pos),   32'd6);
        check("marker_valid", 32'(bus_if.marker_valid), 32'd1);
        bus_if.marker = 1'b0;
        step();
        start_clear(n);
        check("commanded clear length",   32'(n), 32'd160);
        check("clear cur_addr",           32'(bus_if.cur_addr),     32'd0);
        check("clear marker_valid",       32'(bus_if.marker_valid), 32'd0);
        check("clear keeps proto_err 0",  32'(bus_if.proto_err),    32'd0);
        read_at(8'd5, rd);
        check("cell 5 blanked",           32'(rd), 32'(BLANK));

        // Both strobes in one cycle.
        pulse_addr(8'd33);
        bus_if.bus_data     = 8'h07;
        bus_if.write_addr_n = 1'b0;
        bus_if.write_data_n = 1'b0;
        step();
        bus_if.write_addr_n = 1'b1;
        bus_if.write_data_n = 1'b1;
        step();
        check("dual strobe cur_addr",    32'(bus_if.cur_addr),    32'd33);
        check("dual strobe write_count", 32'(bus_if.write_count), 32'd1);
        check("dual strobe proto_err",   32'(bus_if.proto_err),   32'd1);
        check("dual strobe ready",       32'(bus_if.ready),       32'd1);
        read_at(8'd33, rd);
        check("dual strobe no write",    32'(rd), 32'(BLANK));

        // Reset in the middle of a clear restarts the whole sweep.
        bus_if.bus_data     = CLR;
        bus_if.write_addr_n = 1'b0;
        step();
        bus_if.write_addr_n = 1'b1;
        repeat (80) step();
        apply_reset();
        wait_ready(n);
        check("clear after mid-clear reset", 32'(n), 32'd160);

        // Randomized traffic against the model.
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            wait_ready(n);
            check("random round clear length", 32'(n), 32'd160);
            for (int c = 0; c < 600; c++) begin
                bus_if.write_addr_n = ($urandom_range(0, 11) != 0);
                bus_if.write_data_n = ($urandom_range(0, 5) != 0);
                if ($urandom_range(0, 9) == 0) bus_if.marker = ~bus_if.marker;
                if ($urandom_range(0, 9) < 7)
                    bus_if.bus_data = 8'($urandom_range(0, DEPTH - 1));
                else
                    bus_if.bus_data = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 199) == 0) bus_if.bus_data = CLR;
                bus_if.rd_addr = 8'($urandom_range(0, 255));
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
